// File: rtl/seg7_scan_driver.sv
// Multiplexed N-digit 7-segment scan driver with hex/decimal decode, leading-zero
// blanking, decimal points, selectable polarity and frame-synchronous data update.
module seg7_scan_driver #(
  parameter int unsigned N_DIGITS       = 4,
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned SEG_ACTIVE_LOW = 0,
  parameter int unsigned DIG_ACTIVE_LOW = 1
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_enable,
  input  logic                  i_load,
  input  logic [4*N_DIGITS-1:0] i_data,
  input  logic [N_DIGITS-1:0]   i_dp,
  input  logic                  i_hex_mode,
  input  logic                  i_blank_lz,
  output logic [6:0]            o_seg,
  output logic                  o_dp,
  output logic [N_DIGITS-1:0]   o_digit,
  output logic                  o_frame
);

  localparam int unsigned DataW = 4 * N_DIGITS;
  localparam int unsigned IdxW  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int unsigned CntW  = $clog2(SCAN_DIV);
  localparam logic        SegInv = (SEG_ACTIVE_LOW != 0);
  localparam logic        DigInv = (DIG_ACTIVE_LOW != 0);

  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic                frame_q, frame_d;
  logic [DataW-1:0]    act_data_q, act_data_d, pend_data_q, pend_data_d;
  logic [N_DIGITS-1:0] act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
  logic                pend_q, pend_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic [N_DIGITS-1:0] digit_q, digit_d;

  logic tick, wrap;

  function automatic logic [6:0] decode(input logic [3:0] nib, input logic hex);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b1111110;
      4'h1:    seg = 7'b0110000;
      4'h2:    seg = 7'b1101101;
      4'h3:    seg = 7'b1111001;
      4'h4:    seg = 7'b0110011;
      4'h5:    seg = 7'b1011011;
      4'h6:    seg = 7'b1011111;
      4'h7:    seg = 7'b1110000;
      4'h8:    seg = 7'b1111111;
      4'h9:    seg = 7'b1111011;
      4'hA:    seg = hex ? 7'b1110111 : 7'b0000000;
      4'hB:    seg = hex ? 7'b0011111 : 7'b0000000;
      4'hC:    seg = hex ? 7'b1001110 : 7'b0000000;
      4'hD:    seg = hex ? 7'b0111101 : 7'b0000000;
      4'hE:    seg = hex ? 7'b1001111 : 7'b0000000;
      default: seg = hex ? 7'b1000111 : 7'b0000000;
    endcase
    return seg;
  endfunction

  assign tick = i_enable && (cnt_q == CntW'(SCAN_DIV - 1));
  assign wrap = tick && (idx_q == IdxW'(N_DIGITS - 1));

  // Prescaler and digit index
  always_comb begin
    cnt_d   = '0;
    idx_d   = '0;
    frame_d = 1'b0;
    if (i_enable) begin
      cnt_d   = tick ? '0 : cnt_q + 1'b1;
      idx_d   = wrap ? '0 : (tick ? idx_q + 1'b1 : idx_q);
      frame_d = wrap;
    end
  end

  // Active data only moves at a frame boundary (or freely while dark)
  always_comb begin
    act_data_d  = act_data_q;
    act_dp_d    = act_dp_q;
    pend_data_d = pend_data_q;
    pend_dp_d   = pend_dp_q;
    pend_d      = pend_q;
    if (!i_enable || wrap) begin
      if (i_load) begin
        act_data_d = i_data;
        act_dp_d   = i_dp;
        pend_d     = 1'b0;
      end else if (wrap && pend_q) begin
        act_data_d = pend_data_q;
        act_dp_d   = pend_dp_q;
        pend_d     = 1'b0;
      end
    end else if (i_load) begin
      pend_data_d = i_data;
      pend_dp_d   = i_dp;
      pend_d      = 1'b1;
    end
  end

  // Outputs are decoded from next-state so they track idx one cycle after the tick
  always_comb begin
    logic                above;
    logic [N_DIGITS-1:0] zero_above;
    logic [3:0]          nib;
    logic                dp_raw, blank;
    logic [6:0]          seg_raw;
    logic [N_DIGITS-1:0] dig_raw;
    above      = 1'b1;
    zero_above = '0;
    nib        = 4'h0;
    dp_raw     = 1'b0;
    blank      = 1'b0;
    dig_raw    = '0;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      above         = above & (act_data_d[4*k +: 4] == 4'h0);
      zero_above[k] = above;
    end
    for (int k = 0; k < N_DIGITS; k++) begin
      if (idx_d == IdxW'(k)) begin
        nib        = act_data_d[4*k +: 4];
        dp_raw     = act_dp_d[k];
        blank      = i_blank_lz && (k != 0) && zero_above[k];
        dig_raw[k] = 1'b1;
      end
    end
    seg_raw = blank ? 7'b0000000 : decode(nib, i_hex_mode);
    if (!i_enable) begin
      seg_raw = '0;
      dp_raw  = 1'b0;
      dig_raw = '0;
    end
    seg_d   = SegInv ? ~seg_raw : seg_raw;
    dp_d    = SegInv ? ~dp_raw : dp_raw;
    digit_d = DigInv ? ~dig_raw : dig_raw;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      frame_q     <= 1'b0;
      act_data_q  <= '0;
      act_dp_q    <= '0;
      pend_data_q <= '0;
      pend_dp_q   <= '0;
      pend_q      <= 1'b0;
      seg_q       <= {7{SegInv}};
      dp_q        <= SegInv;
      digit_q     <= {N_DIGITS{DigInv}};
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      frame_q     <= frame_d;
      act_data_q  <= act_data_d;
      act_dp_q    <= act_dp_d;
      pend_data_q <= pend_data_d;
      pend_dp_q   <= pend_dp_d;
      pend_q      <= pend_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      digit_q     <= digit_d;
    end
  end

  assign o_seg   = seg_q;
  assign o_dp    = dp_q;
  assign o_digit = digit_q;
  assign o_frame = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: an active-high and an inverted-polarity
// instance share stimulus; expectations are queued by cycle and checked by a monitor.
module tb_seg7_scan_driver;

  localparam logic [6:0] S0 = 7'b1111110, S1 = 7'b0110000, S2 = 7'b1101101;
  localparam logic [6:0] S3 = 7'b1111001, S4 = 7'b0110011, S8 = 7'b1111111;
  localparam logic [6:0] S9 = 7'b1111011, SA = 7'b1110111, SF = 7'b1000111;
  localparam logic [6:0] SX = 7'b0000000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        load = 1'b0;
  logic [15:0] data = '0;
  logic [3:0]  dp = '0;
  logic        hex = 1'b0;
  logic        blank = 1'b0;

  logic [6:0] seg_a, seg_b;
  logic       dp_a, dp_b, frame_a, frame_b;
  logic [3:0] dig_a, dig_b;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    int         cyc;
    logic [3:0] dig;
    logic [6:0] seg;
    logic       dp;
    logic       frm;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  seg7_scan_driver #(
    .N_DIGITS(4), .SCAN_DIV(4), .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0)
  ) u_dut (
    .i_clk(clk), .i_reset(rst), .i_enable(enable), .i_load(load), .i_data(data),
    .i_dp(dp), .i_hex_mode(hex), .i_blank_lz(blank), .o_seg(seg_a), .o_dp(dp_a),
    .o_digit(dig_a), .o_frame(frame_a)
  );

  seg7_scan_driver #(
    .N_DIGITS(4), .SCAN_DIV(4), .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)
  ) u_dut_inv (
    .i_clk(clk), .i_reset(rst), .i_enable(enable), .i_load(load), .i_data(data),
    .i_dp(dp), .i_hex_mode(hex), .i_blank_lz(blank), .o_seg(seg_b), .o_dp(dp_b),
    .o_digit(dig_b), .o_frame(frame_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int c, input logic [3:0] dg, input logic [6:0] sg,
                      input logic d, input logic f);
    exp_t x;
    x.cyc = c; x.dig = dg; x.seg = sg; x.dp = d; x.frm = f;
    sb.push_back(x);
  endtask

  task automatic chk(input string name, input int c, input logic [6:0] got,
                     input logic [6:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%b want=%b", name, c, got, want);
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: compare both instances whenever a queued expectation falls due
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      if (e.cyc < cyc) begin
        n_checks++;
        n_fail++;
        $display("FAIL missed cyc=%0d now=%0d", e.cyc, cyc);
      end else begin
        chk("digit", cyc, {3'b0, dig_a}, {3'b0, e.dig});
        chk("seg", cyc, seg_a, e.seg);
        chk("dp", cyc, {6'b0, dp_a}, {6'b0, e.dp});
        chk("frame", cyc, {6'b0, frame_a}, {6'b0, e.frm});
        chk("digit_inv", cyc, {3'b0, dig_b}, {3'b0, ~e.dig});
        chk("seg_inv", cyc, seg_b, ~e.seg);
        chk("dp_inv", cyc, {6'b0, dp_b}, {6'b0, ~e.dp});
        chk("frame_inv", cyc, {6'b0, frame_b}, {6'b0, e.frm});
      end
    end
  end

  initial begin
    int d, q;
    // Reset held: everything inactive
    wait_cyc(2);
    push(3, 4'b0000, SX, 1'b0, 1'b0);
    wait_cyc(3);
    rst = 1'b0; load = 1'b1; data = 16'h1234; dp = 4'b0000;  // load while dark
    wait_cyc(4);
    load = 1'b0; enable = 1'b1; hex = 1'b1;
    d = 4;
    push(d,      4'b0000, SX, 0, 0);
    push(d + 1,  4'b0001, S4, 0, 0);
    push(d + 5,  4'b0010, S3, 0, 0);
    push(d + 9,  4'b0100, S2, 0, 0);
    push(d + 13, 4'b1000, S1, 0, 0);
    push(d + 15, 4'b1000, S1, 0, 0);
    push(d + 16, 4'b0001, S4, 0, 1);
    push(d + 17, 4'b0001, S4, 0, 0);

    // Mid-frame load shows only from the next frame; wrap-coincident load is immediate
    wait_cyc(d + 21);
    push(d + 25, 4'b0100, S2, 0, 0);
    push(d + 29, 4'b1000, S1, 0, 0);
    push(d + 32, 4'b0001, S9, 0, 1);
    push(d + 33, 4'b0001, S9, 0, 0);
    push(d + 47, 4'b1000, S9, 0, 0);
    push(d + 48, 4'b0001, SF, 0, 1);
    push(d + 49, 4'b0001, SF, 0, 0);
    push(d + 53, 4'b0010, SA, 0, 0);
    push(d + 57, 4'b0100, S0, 1, 0);
    push(d + 61, 4'b1000, S0, 0, 0);
    load = 1'b1; data = 16'h9999;
    wait_cyc(d + 22);
    load = 1'b0;
    wait_cyc(d + 47);
    load = 1'b1; data = 16'h00AF; dp = 4'b0100;
    wait_cyc(d + 48);
    load = 1'b0;

    // Live decimal mode, then leading-zero blanking (dp unaffected)
    wait_cyc(d + 63);
    push(d + 65, 4'b0001, SX, 0, 0);
    push(d + 69, 4'b0010, SX, 0, 0);
    push(d + 73, 4'b0100, SX, 1, 0);
    push(d + 77, 4'b1000, SX, 0, 0);
    hex = 1'b0;
    wait_cyc(d + 71);
    blank = 1'b1;

    // Last pending load wins; zero below a nonzero digit is not blanked; then disable
    wait_cyc(d + 81);
    push(d + 97,  4'b0001, S2, 0, 0);
    push(d + 101, 4'b0010, S0, 0, 0);
    push(d + 105, 4'b0100, S1, 0, 0);
    push(d + 109, 4'b1000, SX, 0, 0);
    push(d + 111, 4'b0000, SX, 0, 0);
    push(d + 112, 4'b0000, SX, 0, 0);
    load = 1'b1; data = 16'h0000; dp = 4'b0000;
    wait_cyc(d + 82);
    load = 1'b0;
    wait_cyc(d + 85);
    load = 1'b1; data = 16'h0102;
    wait_cyc(d + 86);
    load = 1'b0;
    wait_cyc(d + 110);
    enable = 1'b0;

    // Re-enable, then reset mid-scan with a pending load
    q = d + 114;
    wait_cyc(q);
    push(q + 3,  4'b0001, S2, 0, 0);
    push(q + 8,  4'b0000, SX, 0, 0);
    push(q + 9,  4'b0001, S0, 0, 0);
    push(q + 13, 4'b0010, SX, 0, 0);
    push(q + 24, 4'b0001, S0, 0, 1);
    push(q + 25, 4'b0001, S0, 0, 0);
    enable = 1'b1;
    wait_cyc(q + 5);
    load = 1'b1; data = 16'h7777;
    wait_cyc(q + 6);
    load = 1'b0;
    wait_cyc(q + 7);
    rst = 1'b1;
    wait_cyc(q + 8);
    rst = 1'b0;
    wait_cyc(q + 30);

    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain left=%0d want=0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
